// File: rtl/servo_pkg.sv
// ----------------------------------------------------------------------------
// servo_pkg
// Shared widths, default timing constants and helpers for the servo pulse
// generator.
//   US_W   : width of any microsecond pulse-width value
//   CNT_W  : width of the microsecond frame counter
//   DEF_*  : default frame length and width window, in microseconds
//   us_t   : microsecond pulse-width type
//   clamp_us() : saturate a width into a [lo, hi] window
// ----------------------------------------------------------------------------
package servo_pkg;

    localparam int US_W  = 11;
    localparam int CNT_W = 15;

    localparam int DEF_PERIOD_US = 20000;
    localparam int DEF_MIN_US    = 1000;
    localparam int DEF_MAX_US    = 2000;
    localparam int DEF_CENTER_US = 1500;

    typedef logic [US_W-1:0] us_t;

    function automatic us_t clamp_us(input us_t value, input us_t lo, input us_t hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// ----------------------------------------------------------------------------
// us_tick_gen
// Divides the system clock down to a one-cycle tick every DIV clocks. The
// prescaler counts 0..DIV-1, and the tick is high while the count is DIV-1.
// That places the first tick on the DIV-th rising edge after reset releases.
//   clk     : system clock
//   rst     : asynchronous active-high reset (count returns to 0)
//   us_tick : high for one clock out of every DIV
// ----------------------------------------------------------------------------
module us_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick
);

    // A divide-by-1 still needs a one-bit counter so that the types stay legal.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign us_tick = (cnt == LAST);

endmodule

// File: rtl/servo_pwm_gen.sv
// ----------------------------------------------------------------------------
// servo_pwm_gen
// Hobby-servo PWM frame generator. The module samples the requested width
// and the enable once per frame. It clamps the width to [MIN_US, MAX_US] and
// optionally slew-limits it. It then drives one registered pulse of exactly
// width_cur microseconds at the start of every PERIOD_US frame.
//   clk         : system clock (CLK_FREQ_HZ, integer multiple of 1 MHz)
//   rst         : asynchronous active-high reset
//   en          : output enable, sampled only at frame boundaries
//   pulse_us    : requested width in microseconds
//   pwm_out     : registered servo pulse
//   frame_start : one-cycle strobe on the first cycle of every frame
//   width_cur   : width applied in the current frame, in microseconds
// ----------------------------------------------------------------------------
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PERIOD_US   = DEF_PERIOD_US,
    parameter int unsigned MIN_US      = DEF_MIN_US,
    parameter int unsigned MAX_US      = DEF_MAX_US,
    parameter int unsigned CENTER_US   = DEF_CENTER_US,
    parameter int unsigned SLEW_US     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [US_W-1:0] pulse_us,
    output logic            pwm_out,
    output logic            frame_start,
    output logic [US_W-1:0] width_cur
);

    localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;

    localparam logic [CNT_W-1:0] LAST_US  = CNT_W'(PERIOD_US - 1);
    localparam us_t              MIN_W    = US_W'(MIN_US);
    localparam us_t              MAX_W    = US_W'(MAX_US);
    localparam us_t              CENTER_W = US_W'(CENTER_US);
    localparam us_t              SLEW_W   = US_W'(SLEW_US);
    // The slew step as a positive 12-bit signed value, so that it compares
    // cleanly against the signed width difference.
    localparam logic signed [US_W:0] SLEW_S = $signed({1'b0, SLEW_W});

    logic                   us_tick;
    logic [CNT_W-1:0]       us_cnt;
    logic                   frame_en;
    logic                   boundary;
    logic                   pulse_end;
    us_t                    target;
    us_t                    width_next;
    logic signed [US_W:0]   diff;

    us_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .us_tick (us_tick)
    );

    // The frame counter starts at PERIOD_US-1, so the very first microsecond
    // tick after reset wraps it to 0 and opens the first frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt <= LAST_US;
        end else if (us_tick) begin
            if (us_cnt == LAST_US) begin
                us_cnt <= '0;
            end else begin
                us_cnt <= us_cnt + 1'b1;
            end
        end
    end

    assign boundary  = us_tick && (us_cnt == LAST_US);
    // The pulse ends on the edge where the counter becomes width_cur. That
    // gives a high time of exactly width_cur * DIV clocks.
    assign pulse_end = us_tick && ((us_cnt + 1'b1) == {{(CNT_W-US_W){1'b0}}, width_cur});

    assign target = clamp_us(pulse_us, MIN_W, MAX_W);
    // Both operands are zero-extended to 12 bits, so the subtraction cannot wrap.
    assign diff   = $signed({1'b0, target}) - $signed({1'b0, width_cur});

    // Next frame width: jump straight to the target unless slew limiting is
    // on and the target lies more than one slew step away.
    always_comb begin
        width_next = target;
        if (SLEW_US != 0) begin
            if (diff > SLEW_S) begin
                width_next = width_cur + SLEW_W;
            end else if (diff < -SLEW_S) begin
                width_next = width_cur - SLEW_W;
            end
        end
    end

    // Width and enable are captured only at the frame boundary. Input changes
    // in mid-frame therefore cannot shorten or stretch the pulse in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_cur   <= CENTER_W;
            frame_en    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (boundary) begin
                width_cur <= width_next;
                frame_en  <= en;
            end
        end
    end

    // The pulse rises together with frame_start when the new frame is
    // enabled. It is held low for the whole of any disabled frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else if (boundary) begin
            pwm_out <= en;
        end else if (pulse_end || !frame_en) begin
            pwm_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// ----------------------------------------------------------------------------
// tb_servo_pwm_gen
// Directed bench for servo_pwm_gen. It runs two instances in lockstep from
// the same clock, reset and enable: dut_a has no slew limit and dut_b has a
// slew limit of 100 us. A 2 MHz clock (DIV = 2) and a 3000 us frame
// (6000 clocks) keep the run short.
// ----------------------------------------------------------------------------
module tb_servo_pwm_gen;

    localparam int DIV   = 2;
    localparam int FRAME = 3000 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] pulse_a;
    logic [10:0] pulse_b;
    logic        pwm_a;
    logic        pwm_b;
    logic        fs_a;
    logic        fs_b;
    logic [10:0] width_a;
    logic [10:0] width_b;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .CLK_FREQ_HZ (2_000_000),
        .PERIOD_US   (3000),
        .MIN_US      (1000),
        .MAX_US      (2000),
        .CENTER_US   (1500),
        .SLEW_US     (0)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pulse_us    (pulse_a),
        .pwm_out     (pwm_a),
        .frame_start (fs_a),
        .width_cur   (width_a)
    );

    servo_pwm_gen #(
        .CLK_FREQ_HZ (2_000_000),
        .PERIOD_US   (3000),
        .MIN_US      (1000),
        .MAX_US      (2000),
        .CENTER_US   (1500),
        .SLEW_US     (100)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pulse_us    (pulse_b),
        .pwm_out     (pwm_b),
        .frame_start (fs_b),
        .width_cur   (width_b)
    );

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input int pa, input int pb);
        en      = e;
        pulse_a = 11'(pa);
        pulse_b = 11'(pb);
    endtask

    // The task is entered on the negedge of a frame's first cycle. It counts
    // the high cycles of both pulses until the next frame_start, and applies
    // new inputs on cycle change_at. The cycle budget guards against a hang.
    task automatic runFrame(input int change_at, input logic e, input int pa, input int pb,
                            output int len, output int high_a, output int high_b);
        int cyc;
        cyc    = 0;
        high_a = 0;
        high_b = 0;
        do begin
            if (pwm_a) high_a++;
            if (pwm_b) high_b++;
            if (cyc == change_at) applyStimulus(e, pa, pb);
            @(negedge clk);
            cyc++;
        end while (!fs_a && cyc < FRAME + 20);
        len = cyc;
    endtask

    task automatic frameCheck(input string tag, input int exp_wa, input int exp_wb,
                              input int exp_pwm, input int change_at, input logic e,
                              input int pa, input int pb, input int exp_ha, input int exp_hb);
        int len;
        int ha;
        int hb;
        checkOutput({tag, "_width_a"}, int'(width_a), exp_wa);
        checkOutput({tag, "_width_b"}, int'(width_b), exp_wb);
        checkOutput({tag, "_pwm_start"}, int'(pwm_a), exp_pwm);
        checkOutput({tag, "_fs_b"}, int'(fs_b), 1);
        runFrame(change_at, e, pa, pb, len, ha, hb);
        checkOutput({tag, "_period"}, len, FRAME);
        checkOutput({tag, "_high_a"}, ha, exp_ha);
        checkOutput({tag, "_high_b"}, hb, exp_hb);
    endtask

    initial begin
        $display("[TB] servo_pwm_gen directed test start");
        rst = 1'b1;
        applyStimulus(1'b0, 1500, 1500);
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm_a", int'(pwm_a), 0);
        checkOutput("rst_pwm_b", int'(pwm_b), 0);
        checkOutput("rst_width_a", int'(width_a), 1500);
        checkOutput("rst_width_b", int'(width_b), 1500);
        checkOutput("rst_fs", int'(fs_a), 0);

        // The first boundary falls on the DIV-th rising edge after release.
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_fs_early", int'(fs_a), 0);
        @(negedge clk);
        checkOutput("first_fs", int'(fs_a), 1);

        // Disabled frame; enable and step both requests mid-frame.
        frameCheck("f1", 1500, 1500, 0, 100, 1'b1, 1500, 2000, 0, 0);
        // Change A to 1800 while the pulse is high; this frame keeps 1500.
        frameCheck("f2", 1500, 1600, 1, 500, 1'b1, 1800, 2000, 3000, 3200);
        // Drop en mid-frame; this frame is unaffected. A requests 2047.
        frameCheck("f3", 1800, 1700, 1, 200, 1'b0, 2047, 2000, 3600, 3400);
        // Disabled frame, widths still advance. Inputs change on the boundary cycle.
        frameCheck("f4", 2000, 1800, 0, FRAME - 1, 1'b1, 300, 2000, 0, 0);
        // A = 300 clamps to 1000; A = 1000 passes unchanged.
        frameCheck("f5", 1000, 1900, 1, 100, 1'b1, 1000, 2000, 2000, 3800);
        frameCheck("f6", 1000, 2000, 1, 100, 1'b1, 0, 1000, 2000, 4000);
        // A = 0 clamps to 1000; B slews down by 100 per frame.
        frameCheck("f7", 1000, 1900, 1, 100, 1'b1, 2000, 1000, 2000, 3800);

        // Frame 8: reset mid-pulse must clear pwm with no clock edge.
        checkOutput("f8_width_a", int'(width_a), 2000);
        checkOutput("f8_width_b", int'(width_b), 1800);
        checkOutput("f8_pwm_start", int'(pwm_a), 1);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pwm_a", int'(pwm_a), 0);
        checkOutput("async_rst_pwm_b", int'(pwm_b), 0);
        @(negedge clk);
        checkOutput("async_rst_width_a", int'(width_a), 1500);
        checkOutput("async_rst_width_b", int'(width_b), 1500);
        checkOutput("async_rst_fs", int'(fs_a), 0);
        applyStimulus(1'b0, 1500, 1500);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rerun_fs_early", int'(fs_a), 0);
        @(negedge clk);
        checkOutput("rerun_fs", int'(fs_a), 1);
        frameCheck("f9", 1500, 1500, 0, -1, 1'b0, 1500, 1500, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo pulse generator that turns the limited 11-bit steering width (microseconds) from the Y-value limiter into a standard hobby-servo PWM frame on a Basys3 pin. It samples the requested width once per frame, clamps it to a safe window, applies an optional per-frame slew limit, and drives a glitch-free pulse. It sits directly downstream of the limiter and is the last stage before the servo output pin.

## Interface
- CLK_FREQ_HZ, 100_000_000 — system clock frequency; must be an integer multiple of 1 MHz.
- PERIOD_US, 20000 — frame length in µs.
- MIN_US, 1000 — lowest width ever applied.
- MAX_US, 2000 — highest width ever applied; must be ≤ 2047 and ≥ MIN_US.
- CENTER_US, 1500 — width applied after reset; must lie within MIN_US..MAX_US.
- SLEW_US, 0 — maximum width change per frame; 0 disables slew limiting.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  output enable; sampled only at frame boundaries.
- pulse_us  in  11  requested width in µs, unsigned; the limiter output.
- pwm_out  out  1  servo pulse, registered.
- frame_start  out  1  one-cycle strobe on the first cycle of each frame.
- width_cur  out  11  width applied in the current frame, in µs.

## Operation
- Prescaler: `DIV = CLK_FREQ_HZ/1_000_000`.
  - Counts 0..DIV-1.
  - `us_tick` is high on the count DIV-1.
- Frame counter `us_cnt` (15 bits): advances on each `us_tick` and wraps from PERIOD_US-1 to 0.
- Frame boundary = the edge where `us_cnt` wraps to 0. On that edge:
  - `target = min(max(pulse_us, MIN_US), MAX_US)`.
  - If SLEW_US = 0: `width_cur <= target`.
  - Otherwise: `width_cur` moves toward `target` by `min(|target − width_cur|, SLEW_US)`.
  - Compute the difference in 12-bit signed arithmetic; no wrap is permitted.
  - `frame_en <= en`.
  - `frame_start <= 1` for exactly one cycle.
- `pwm_out` is registered:
  - Goes to 1 on the boundary edge if the new `frame_en` is 1.
  - Goes to 0 on the edge where `us_cnt` becomes `width_cur`.
  - High time = `width_cur × DIV` clocks exactly.
- Disabled frame (`frame_en` = 0):
  - `pwm_out` stays 0 for the entire frame.
  - `width_cur` still updates, including slew.
- Changes to `pulse_us` or `en` in mid-frame have no effect until the next boundary. This guarantees there are no runt or stretched pulses.

## Timing
- Reset values:
  - prescaler 0
  - `us_cnt` = PERIOD_US-1
  - `width_cur` = CENTER_US
  - `frame_en` 0
  - `pwm_out` 0
  - `frame_start` 0
- First boundary: the DIV-th rising edge after `rst` deasserts.
- Frame period: `PERIOD_US × DIV` clocks (2,000,000 at the defaults).
- Input-to-output latency: `pulse_us` takes effect at the first boundary after it is presented, i.e. at most one frame later.
- Reset asserted mid-pulse: `pwm_out` drops to 0 asynchronously, and all state returns to the reset values.
- `en` and `pulse_us` changing on the boundary cycle itself: the values present at that edge are used.
- `pulse_us` at the clamp bounds:
  - `pulse_us` = MIN_US or MAX_US passes unchanged.
  - `pulse_us` = 0 yields MIN_US.
  - `pulse_us` = 2047 yields MAX_US.

## Structure
- Package `servo_pkg` holds:
  - `localparam US_W = 11`
  - `localparam CNT_W = 15`
  - default constants for PERIOD, MIN, MAX and CENTER
  - typedef `us_t` = `logic [US_W-1:0]`
- Sub-module `us_tick_gen`: parameterised by DIV; inputs `clk` and `rst`; output `us_tick`.
- The frame counter, clamp/slew logic and pulse register live in the top level.

## Test plan
Benches may override CLK_FREQ_HZ to 10 MHz (DIV=10) and PERIOD_US to 3000 to shorten runs.
- Reset, hold `en` = 0 → `pwm_out` 0, `width_cur` = 1500, first `frame_start` at the DIV-th edge after reset release, then every PERIOD_US × DIV clocks.
- `en` = 1, `pulse_us` = 1500 steady → each frame: `pwm_out` high exactly 1500 × DIV clocks starting on the `frame_start` cycle.
- Clamp: `pulse_us` = 2047 → `width_cur` 2000; `pulse_us` = 300 → `width_cur` 1000; `pulse_us` = 1000 → 1000.
- SLEW_US = 100, step `pulse_us` 1500 → 2000 → `width_cur` goes 1600, 1700, 1800, 1900, 2000, 2000 over successive frames. Step down to 1000 → `width_cur` decreases by 100 per frame to 1000.
- Mid-frame change: `pulse_us` 1500 → 1800 while `pwm_out` is high → the current pulse is still 1500 µs; the next frame is 1800 µs. Toggling `en` mid-frame leaves the current frame unchanged.
- Assert `rst` during a pulse → `pwm_out` goes 0 in the same cycle with no clock edge needed; after release the reset timing repeats.
